// File: rtl/jt10_adpcm_rom_arb_if.sv
// ----------------------------------------------------------------------------
// jt10_adpcm_rom_arb_if
// Byte-wide memory read port shared by the ADPCM-A and ADPCM-B ROM channels.
//
// Signals:
//   mem_addr  : read address, driven by the arbiter
//   mem_req   : read request level, driven by the arbiter
//   mem_ack   : one-cycle completion pulse, driven by the memory controller
//   mem_dout  : read data, valid in the cycle mem_ack is high
//
// Handshake: the arbiter raises mem_req with mem_addr and holds both stable
// until the memory answers with a single-cycle mem_ack, which may arrive as
// early as the first cycle of mem_req. That ack consumes the request and
// mem_dout is sampled in the same cycle. mem_req is low for at least one
// cycle between requests. An ack seen while mem_req is low has no meaning.
//
// Modports:
//   master : arbiter side
//   slave  : memory controller side
// ----------------------------------------------------------------------------
interface jt10_adpcm_rom_arb_if #(
    parameter int AW = 25
);
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic          mem_ack;
    logic [7:0]    mem_dout;

    modport master (
        output mem_addr,
        output mem_req,
        input  mem_ack,
        input  mem_dout
    );

    modport slave (
        input  mem_addr,
        input  mem_req,
        output mem_ack,
        output mem_dout
    );
endinterface

// File: rtl/jt10_adpcm_rom_arb.sv
// ----------------------------------------------------------------------------
// jt10_adpcm_rom_arb
// Shares one byte-wide ROM/SDRAM read port between the YM2610 ADPCM-A and
// ADPCM-B ROM interfaces. Each channel has fetch detection, a one-entry tag
// cache and a data byte that holds until its next fetch completes. Misses are
// arbitrated round-robin onto the memory port.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   a_addr, a_roe_n   : ADPCM-A address {bank, addr} and active-low ROM enable
//   a_data, a_busy    : ADPCM-A data byte, fetch pending or in flight
//   b_addr, b_roe_n   : ADPCM-B address and active-low ROM enable
//   b_data, b_busy    : ADPCM-B data byte, fetch pending or in flight
//   mem               : memory read port (master side)
//   dbg_state         : arbiter state (0 idle, 1 request, 2 wait)
// ----------------------------------------------------------------------------
module jt10_adpcm_rom_arb #(
    parameter int            AW     = 25,
    parameter logic [AW-1:0] B_BASE = AW'(25'h100_0000)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [23:0]          a_addr,
    input  logic                 a_roe_n,
    output logic [7:0]           a_data,
    output logic                 a_busy,
    input  logic [23:0]          b_addr,
    input  logic                 b_roe_n,
    output logic [7:0]           b_data,
    output logic                 b_busy,
    jt10_adpcm_rom_arb_if.master mem,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    state_t        state, state_nxt;
    logic          sel, sel_nxt;     // channel owning the memory port
    logic          rr, rr_nxt;       // channel that won the last tie
    logic          go;               // a miss is launched this cycle

    logic          roe_d_a, roe_d_b;
    logic [23:0]   req_a, req_b;     // last captured address per channel
    logic [23:0]   tag_a, tag_b;     // address of the byte held in X_data
    logic [23:0]   fl_addr;          // channel address of the fetch in flight
    logic          pend_a, pend_b;
    logic          valid_a, valid_b;
    logic [AW-1:0] mem_addr_q;

    logic          cap_a, cap_b;
    logic          fly_a, fly_b;
    logic          hit_a, hit_b;
    logic          miss_a, miss_b;
    logic          ack;

    // A fetch starts on a falling enable or on an address change while the
    // enable stays low.
    assign cap_a = ~a_roe_n & (roe_d_a | (a_addr != req_a));
    assign cap_b = ~b_roe_n & (roe_d_b | (b_addr != req_b));

    assign fly_a = (state != IDLE) & (sel == CH_A);
    assign fly_b = (state != IDLE) & (sel == CH_B);

    // The tag may not be trusted while the same channel is in flight: the
    // returning byte is about to overwrite it.
    assign hit_a = pend_a & ~fly_a & valid_a & (req_a == tag_a);
    assign hit_b = pend_b & ~fly_b & valid_b & (req_b == tag_b);

    assign miss_a = pend_a & ~hit_a;
    assign miss_b = pend_b & ~hit_b;

    // Acks outside a transaction are stray and dropped.
    assign ack = mem.mem_ack & (state != IDLE);

    assign a_busy       = pend_a | fly_a;
    assign b_busy       = pend_b | fly_b;
    assign mem.mem_req  = (state != IDLE);
    assign mem.mem_addr = mem_addr_q;
    assign dbg_state    = state;

    // ------------------------------------------------------------------
    // Arbiter next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        rr_nxt    = rr;
        go        = 1'b0;
        case (state)
            IDLE: begin
                if (miss_a && miss_b) begin
                    go      = 1'b1;
                    sel_nxt = ~rr;
                    rr_nxt  = ~rr;
                end else if (miss_a) begin
                    go      = 1'b1;
                    sel_nxt = CH_A;
                end else if (miss_b) begin
                    go      = 1'b1;
                    sel_nxt = CH_B;
                end
                if (go) begin
                    state_nxt = REQ;
                end
            end
            REQ:     state_nxt = ack ? IDLE : WAIT;
            WAIT:    state_nxt = ack ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= CH_A;
            rr    <= CH_A;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            rr    <= rr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Channel capture, cache and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roe_d_a    <= 1'b1;
            roe_d_b    <= 1'b1;
            req_a      <= '0;
            req_b      <= '0;
            tag_a      <= '0;
            tag_b      <= '0;
            fl_addr    <= '0;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            valid_a    <= 1'b0;
            valid_b    <= 1'b0;
            a_data     <= '0;
            b_data     <= '0;
            mem_addr_q <= '0;
        end else begin
            roe_d_a <= a_roe_n;
            roe_d_b <= b_roe_n;

            if (cap_a) begin
                req_a <= a_addr;
            end
            if (cap_b) begin
                req_b <= b_addr;
            end

            // pend is handed over to the in-flight state at launch; a capture
            // always wins so a newer address is never lost.
            if (cap_a) begin
                pend_a <= 1'b1;
            end else if (hit_a || (go && sel_nxt == CH_A)) begin
                pend_a <= 1'b0;
            end
            if (cap_b) begin
                pend_b <= 1'b1;
            end else if (hit_b || (go && sel_nxt == CH_B)) begin
                pend_b <= 1'b0;
            end

            if (go) begin
                fl_addr    <= (sel_nxt == CH_B) ? req_b : req_a;
                // B sits at B_BASE and wraps within the AW-bit space.
                mem_addr_q <= (sel_nxt == CH_B) ? (B_BASE + AW'(req_b)) : AW'(req_a);
            end

            if (ack) begin
                if (sel == CH_A) begin
                    a_data  <= mem.mem_dout;
                    tag_a   <= fl_addr;
                    valid_a <= 1'b1;
                end else begin
                    b_data  <= mem.mem_dout;
                    tag_b   <= fl_addr;
                    valid_b <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt10_adpcm_rom_arb.sv
// ----------------------------------------------------------------------------
// tb_jt10_adpcm_rom_arb
// Directed scenarios followed by randomized channel traffic against a memory
// model with random latency. A channel's data byte is predicted from the
// memory image at the address it presents whenever it is quiet.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jt10_adpcm_rom_arb;

    localparam int            AW      = 25;
    localparam logic [AW-1:0] B_BASE0 = 25'h100_0000;
    localparam logic [AW-1:0] B_BASE1 = 25'h180_0000;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // DUTs
    // ------------------------------------------------------------------
    logic [23:0] a_addr, b_addr;
    logic        a_roe_n, b_roe_n;
    logic [7:0]  a_data, b_data;
    logic        a_busy, b_busy;
    logic [1:0]  dbg_state;

    jt10_adpcm_rom_arb_if #(.AW(AW)) mem_if ();

    jt10_adpcm_rom_arb #(.AW(AW), .B_BASE(B_BASE0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_addr    (a_addr),
        .a_roe_n   (a_roe_n),
        .a_data    (a_data),
        .a_busy    (a_busy),
        .b_addr    (b_addr),
        .b_roe_n   (b_roe_n),
        .b_data    (b_data),
        .b_busy    (b_busy),
        .mem       (mem_if),
        .dbg_state (dbg_state)
    );

    // Second instance only exercises the wrapping B offset.
    logic [23:0] a_addr1, b_addr1;
    logic        a_roe_n1, b_roe_n1;
    logic [7:0]  a_data1, b_data1;
    logic        a_busy1, b_busy1;
    logic [1:0]  dbg_state1;

    jt10_adpcm_rom_arb_if #(.AW(AW)) mem_if1 ();

    jt10_adpcm_rom_arb #(.AW(AW), .B_BASE(B_BASE1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_addr    (a_addr1),
        .a_roe_n   (a_roe_n1),
        .a_data    (a_data1),
        .a_busy    (a_busy1),
        .b_addr    (b_addr1),
        .b_roe_n   (b_roe_n1),
        .b_data    (b_data1),
        .b_busy    (b_busy1),
        .mem       (mem_if1),
        .dbg_state (dbg_state1)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [AW-1:0] exp_q[$];          // expected mem_addr of each new request
    bit            strict_req;        // a request with nothing expected is an error
    logic [7:0]    mem_img [logic [AW-1:0]];
    bit            mem_en;
    int            mem_lat_fixed;
    int            lat_cnt;
    bit            acked;
    logic          prev_req;
    logic [AW-1:0] prev_maddr;
    logic          h1_a_roe, h2_a_roe, h1_b_roe, h2_b_roe;
    logic [23:0]   h1_a_addr, h2_a_addr, h1_b_addr, h2_b_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [AW-1:0] ad);
        return ad[7:0] ^ ad[15:8] ^ ad[23:16] ^ {7'd0, ad[24]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [AW-1:0] ad);
        if (mem_img.exists(ad)) return mem_img[ad];
        return mem_byte(ad);
    endfunction

    function automatic logic [AW-1:0] map_a(input logic [23:0] ad);
        return {1'b0, ad};
    endfunction

    function automatic logic [AW-1:0] map_b(input logic [23:0] ad);
        return B_BASE0 + {1'b0, ad};
    endfunction

    // Observes the cycle that just closed; runs once per negedge.
    task automatic monitor();
        logic [AW-1:0] e;
        if (!rst_n) begin
            h1_a_roe = 1'b1; h2_a_roe = 1'b1;
            h1_b_roe = 1'b1; h2_b_roe = 1'b1;
            prev_req = 1'b0;
            return;
        end
        h2_a_roe = h1_a_roe; h2_a_addr = h1_a_addr;
        h2_b_roe = h1_b_roe; h2_b_addr = h1_b_addr;
        h1_a_roe = a_roe_n;  h1_a_addr = a_addr;
        h1_b_roe = b_roe_n;  h1_b_addr = b_addr;

        // A quiet channel presenting a stable address holds that address's byte.
        if (!h1_a_roe && !h2_a_roe && h1_a_addr == h2_a_addr && !a_busy)
            check_eq("a_quiet_data", 32'(a_data), 32'(mem_rd(map_a(h1_a_addr))));
        if (!h1_b_roe && !h2_b_roe && h1_b_addr == h2_b_addr && !b_busy)
            check_eq("b_quiet_data", 32'(b_data), 32'(mem_rd(map_b(h1_b_addr))));

        // Request/ack protocol
        if (prev_req && !mem_if.mem_ack) begin
            check_eq("req_hold", 32'(mem_if.mem_req), 32'(1));
            check_eq("addr_hold", 32'(mem_if.mem_addr), 32'(prev_maddr));
        end
        if (prev_req && mem_if.mem_ack)
            check_eq("req_drop", 32'(mem_if.mem_req), 32'(0));

        if (mem_if.mem_req && !prev_req) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("req_addr", 32'(mem_if.mem_addr), 32'(e));
            end else if (strict_req) begin
                check_eq("unexp_req", 32'(mem_if.mem_req), 32'(0));
            end
        end
        prev_req   = mem_if.mem_req;
        prev_maddr = mem_if.mem_addr;
    endtask

    // Memory controller model: acks a request after lat_cnt idle cycles.
    task automatic mem_model();
        if (!rst_n || !mem_if.mem_req) begin
            mem_if.mem_ack = 1'b0;
            acked   = 1'b0;
            lat_cnt = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 4));
        end else if (acked) begin
            mem_if.mem_ack = 1'b0;
        end else if (lat_cnt == 0) begin
            mem_if.mem_ack  = 1'b1;
            mem_if.mem_dout = mem_rd(mem_if.mem_addr);
            acked = 1'b1;
        end else begin
            mem_if.mem_ack = 1'b0;
            lat_cnt--;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        if (mem_en) mem_model();
    endtask

    task automatic wait_quiet(input string tag, input int max_cyc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while ((a_busy || b_busy) && k < max_cyc);
        check_eq({tag, "_quiet"}, 32'(a_busy | b_busy), 32'(0));
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] pool [8];
        logic [7:0]  old;
        int          n;

        pool = '{24'h000000, 24'h000001, 24'h012345, 24'h0ABCDE,
                 24'hFFFFFF, 24'hFFFFFE, 24'h7F0010, 24'h000011};

        rst_n = 1'b0;
        a_addr = '0; b_addr = '0; a_roe_n = 1'b1; b_roe_n = 1'b1;
        a_addr1 = '0; b_addr1 = '0; a_roe_n1 = 1'b1; b_roe_n1 = 1'b1;
        mem_if.mem_ack = 1'b0;  mem_if.mem_dout = '0;
        mem_if1.mem_ack = 1'b0; mem_if1.mem_dout = '0;
        mem_en = 1'b1; mem_lat_fixed = -1; strict_req = 1'b1;
        prev_req = 1'b0; prev_maddr = '0;
        h1_a_roe = 1'b1; h2_a_roe = 1'b1; h1_b_roe = 1'b1; h2_b_roe = 1'b1;
        h1_a_addr = '0; h2_a_addr = '0; h1_b_addr = '0; h2_b_addr = '0;

        // Reset values
        repeat (3) step();
        check_eq("rst_a_data", 32'(a_data), 32'(0));
        check_eq("rst_b_data", 32'(b_data), 32'(0));
        check_eq("rst_a_busy", 32'(a_busy), 32'(0));
        check_eq("rst_b_busy", 32'(b_busy), 32'(0));
        check_eq("rst_mem_req", 32'(mem_if.mem_req), 32'(0));
        check_eq("rst_mem_addr", 32'(mem_if.mem_addr), 32'(0));
        rst_n = 1'b1;
        step();

        // Single miss on A, memory acks 3 cycles after the request
        mem_img[25'h0012345] = 8'hA5;
        mem_lat_fixed = 3;
        exp_q.push_back(25'h0012345);
        a_addr = 24'h012345; a_roe_n = 1'b0;
        step();
        check_eq("t1_busy", 32'(a_busy), 32'(1));
        check_eq("t1_req_early", 32'(mem_if.mem_req), 32'(0));
        step();
        check_eq("t1_req", 32'(mem_if.mem_req), 32'(1));
        check_eq("t1_maddr", 32'(mem_if.mem_addr), 32'(25'h0012345));
        n = 2;
        while (a_data !== 8'hA5 && n < 30) begin
            step();
            n++;
        end
        check_eq("t1_latency", 32'(n), 32'(6));
        check_eq("t1_data", 32'(a_data), 32'(8'hA5));
        check_eq("t1_req_off", 32'(mem_if.mem_req), 32'(0));
        check_eq("t1_busy_off", 32'(a_busy), 32'(0));

        // Same address again: cache hit, no memory access
        a_roe_n = 1'b1;
        step();
        check_eq("t2_hold_high", 32'(a_data), 32'(8'hA5));
        a_roe_n = 1'b0;
        step();
        check_eq("t2_busy", 32'(a_busy), 32'(1));
        step();
        check_eq("t2_busy_off", 32'(a_busy), 32'(0));
        check_eq("t2_data", 32'(a_data), 32'(8'hA5));
        check_eq("t2_no_req", 32'(mem_if.mem_req), 32'(0));
        repeat (3) step();

        // Simultaneous A and B misses: B first (tie after reset), then A
        mem_lat_fixed = -1;
        a_roe_n = 1'b1; b_roe_n = 1'b1;
        step();
        exp_q.push_back(map_b(24'h0ABCDE));
        exp_q.push_back(map_a(24'h000777));
        a_addr = 24'h000777; b_addr = 24'h0ABCDE; a_roe_n = 1'b0; b_roe_n = 1'b0;
        wait_quiet("t3a", 60);
        check_eq("t3a_order", 32'(exp_q.size()), 32'(0));
        check_eq("t3a_a_data", 32'(a_data), 32'(mem_rd(25'h0000777)));
        check_eq("t3a_b_data", 32'(b_data), 32'(mem_rd(25'h10ABCDE)));

        // Next tie goes to A first
        a_roe_n = 1'b1; b_roe_n = 1'b1;
        step();
        exp_q.push_back(map_a(24'h000888));
        exp_q.push_back(map_b(24'h0BBBBB));
        a_addr = 24'h000888; b_addr = 24'h0BBBBB; a_roe_n = 1'b0; b_roe_n = 1'b0;
        wait_quiet("t3b", 60);
        check_eq("t3b_order", 32'(exp_q.size()), 32'(0));
        check_eq("t3b_a_data", 32'(a_data), 32'(mem_rd(25'h0000888)));
        check_eq("t3b_b_data", 32'(b_data), 32'(mem_rd(25'h10BBBBB)));

        // B offset at the top of the space, with and without wrap
        b_roe_n = 1'b1;
        step();
        exp_q.push_back(25'h1FFFFFF);
        b_addr = 24'hFFFFFF; b_roe_n = 1'b0;
        wait_quiet("t4", 60);
        check_eq("t4_order", 32'(exp_q.size()), 32'(0));
        check_eq("t4_b_data", 32'(b_data), 32'(mem_rd(25'h1FFFFFF)));
        b_addr1 = 24'hFFFFFF; b_roe_n1 = 1'b0;
        repeat (3) step();
        check_eq("t4_wrap_req", 32'(mem_if1.mem_req), 32'(1));
        check_eq("t4_wrap_addr", 32'(mem_if1.mem_addr), 32'(25'h07FFFFF));

        // Address change while the old fetch is in flight
        mem_lat_fixed = 3;
        a_roe_n = 1'b1;
        step();
        old = a_data;
        exp_q.push_back(25'h0000010);
        exp_q.push_back(25'h0000011);
        a_addr = 24'h000010; a_roe_n = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_if.mem_req && n < 10);
        check_eq("t5_req", 32'(mem_if.mem_req), 32'(1));
        a_addr = 24'h000011;
        n = 0;
        while (a_data === old && n < 30) begin
            step();
            n++;
        end
        check_eq("t5_first_data", 32'(a_data), 32'(mem_rd(25'h0000010)));
        check_eq("t5_still_busy", 32'(a_busy), 32'(1));
        wait_quiet("t5", 60);
        check_eq("t5_second_data", 32'(a_data), 32'(mem_rd(25'h0000011)));
        check_eq("t5_order", 32'(exp_q.size()), 32'(0));

        // Reset while waiting on memory, then a stray ack
        mem_en = 1'b0;
        mem_if.mem_ack = 1'b0;
        exp_q.push_back(25'h0000020);
        a_addr = 24'h000020;
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_if.mem_req && n < 10);
        step();
        step();
        check_eq("t6_req_wait", 32'(mem_if.mem_req), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_req_rst", 32'(mem_if.mem_req), 32'(0));
        check_eq("t6_a_data_rst", 32'(a_data), 32'(0));
        check_eq("t6_b_data_rst", 32'(b_data), 32'(0));
        a_roe_n = 1'b1; b_roe_n = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        mem_if.mem_ack = 1'b1; mem_if.mem_dout = 8'hEE;
        step();
        mem_if.mem_ack = 1'b0;
        repeat (4) begin
            step();
            check_eq("t6_stray_data", 32'(a_data), 32'(0));
            check_eq("t6_stray_req", 32'(mem_if.mem_req), 32'(0));
        end
        check_eq("t6_b_data", 32'(b_data), 32'(0));

        // Randomized traffic on both channels
        strict_req = 1'b0; mem_en = 1'b1; mem_lat_fixed = -1;
        exp_q.delete();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)  a_addr = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) a_roe_n = ~a_roe_n;
            if ($urandom_range(0, 7) == 0)  b_addr = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 15) == 0) b_roe_n = ~b_roe_n;
            step();
        end
        a_roe_n = 1'b0; b_roe_n = 1'b0;
        wait_quiet("rand_end", 100);
        check_eq("rand_a_final", 32'(a_data), 32'(mem_rd(map_a(a_addr))));
        check_eq("rand_b_final", 32'(b_data), 32'(mem_rd(map_b(b_addr))));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
